// File: rtl/freeze_ctrl.sv
// rtl/freeze_ctrl.sv - multi-enemy contact freeze controller with prescaled freeze and grace timers
module freeze_ctrl #(
    parameter int N_ENEMY      = 4,
    parameter int FOOT_DX      = 24,
    parameter int FOOT_DY      = 41,
    parameter int HIT_W        = 62,
    parameter int HIT_TOL      = 2,
    parameter int TICK_DIV     = 6000000,
    parameter int FREEZE_TICKS = 256,
    parameter int GRACE_TICKS  = 64,
    parameter int RETRIGGER    = 0,
    localparam int HID_W       = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              x_player,
    input  logic [8:0]              y_player,
    input  logic [10*N_ENEMY-1:0]   x_enemy,
    input  logic [9*N_ENEMY-1:0]    y_enemy,
    input  logic [N_ENEMY-1:0]      enemy_en,
    output logic                    frozen,
    output logic                    grace,
    output logic [HID_W-1:0]        hit_id,
    output logic [15:0]             ticks_left,
    output logic                    thaw
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FROZEN, S_GRACE} state_t;

    state_t             state;
    logic [PW-1:0]      presc;
    logic               tick;
    logic [11:0]        fx;
    logic [11:0]        fy;
    logic [N_ENEMY-1:0] contact;
    logic               any_hit;
    logic [HID_W-1:0]   winner;

    // Foot point; 12-bit working width so no sum can wrap.
    assign fx   = {2'b00, x_player} + 12'(FOOT_DX);
    assign fy   = {3'b000, y_player} + 12'(FOOT_DY);
    assign tick = (presc == PW'(TICK_DIV - 1));

    for (genvar i = 0; i < N_ENEMY; i++) begin : g_ch
        logic [11:0] xe;
        logic [11:0] ye;
        assign xe = {2'b00, x_enemy[10*i +: 10]};
        assign ye = {3'b000, y_enemy[9*i +: 9]};
        assign contact[i] = enemy_en[i]
                          & (fx > xe) & (fx < xe + 12'(HIT_W))
                          & (fy + 12'(HIT_TOL) > ye) & (fy < ye + 12'(HIT_TOL));
    end

    // Lowest-index contacting channel wins; scan from the top so index 0 overrides.
    always_comb begin
        any_hit = 1'b0;
        winner  = '0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (contact[i]) begin
                any_hit = 1'b1;
                winner  = HID_W'(i);
            end
        end
    end

    // Phase sequencer: IDLE -> FROZEN -> (GRACE) -> IDLE, with registered outputs and tick prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            frozen     <= 1'b0;
            grace      <= 1'b0;
            hit_id     <= '0;
            ticks_left <= '0;
            thaw       <= 1'b0;
            presc      <= '0;
        end else begin
            thaw  <= 1'b0;
            presc <= tick ? '0 : presc + PW'(1);
            case (state)
                S_IDLE: begin
                    if (any_hit) begin
                        state      <= S_FROZEN;
                        frozen     <= 1'b1;
                        hit_id     <= winner;
                        ticks_left <= 16'(FREEZE_TICKS);
                        presc      <= '0;
                    end
                end
                S_FROZEN: begin
                    if ((RETRIGGER != 0) && any_hit) begin
                        // A retrigger beats a coinciding final tick.
                        hit_id     <= winner;
                        ticks_left <= 16'(FREEZE_TICKS);
                        presc      <= '0;
                    end else if (tick) begin
                        if (ticks_left == 16'd1) begin
                            frozen <= 1'b0;
                            thaw   <= 1'b1;
                            if (GRACE_TICKS > 0) begin
                                state      <= S_GRACE;
                                grace      <= 1'b1;
                                ticks_left <= 16'(GRACE_TICKS);
                                presc      <= '0;
                            end else begin
                                state      <= S_IDLE;
                                ticks_left <= '0;
                            end
                        end else begin
                            ticks_left <= ticks_left - 16'd1;
                        end
                    end
                end
                S_GRACE: begin
                    if (tick) begin
                        if (ticks_left == 16'd1) begin
                            state      <= S_IDLE;
                            grace      <= 1'b0;
                            ticks_left <= '0;
                        end else begin
                            ticks_left <= ticks_left - 16'd1;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    frozen     <= 1'b0;
                    grace      <= 1'b0;
                    ticks_left <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freeze_ctrl.sv
// tb/tb_freeze_ctrl.sv - self-checking bench for freeze_ctrl (three configurations side by side)
module tb_freeze_ctrl;

    localparam int D = 4;
    localparam int F = 3;
    localparam int RT[3] = '{0, 1, 0};
    localparam int GT[3] = '{2, 2, 0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x_player = 10'd100;
    logic [8:0]  y_player = 9'd100;
    logic [39:0] x_enemy = '0;
    logic [35:0] y_enemy = '0;
    logic [3:0]  enemy_en = '0;

    logic        frz[3];
    logic        grc[3];
    logic        thw_o[3];
    logic [1:0]  hid_o[3];
    logic [15:0] tl[3];

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // model state per instance: phase 0 idle / 1 frozen / 2 grace, remaining cycles in phase
    int m_ph[3] = '{0, 0, 0};
    int m_rem[3] = '{0, 0, 0};
    int m_hid[3] = '{0, 0, 0};
    int m_thw[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    freeze_ctrl #(.TICK_DIV(D), .FREEZE_TICKS(F), .GRACE_TICKS(2), .RETRIGGER(0)) dut (
        .clk(clk), .rst_n(rst_n), .x_player(x_player), .y_player(y_player),
        .x_enemy(x_enemy), .y_enemy(y_enemy), .enemy_en(enemy_en),
        .frozen(frz[0]), .grace(grc[0]), .hit_id(hid_o[0]), .ticks_left(tl[0]), .thaw(thw_o[0]));

    freeze_ctrl #(.TICK_DIV(D), .FREEZE_TICKS(F), .GRACE_TICKS(2), .RETRIGGER(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .x_player(x_player), .y_player(y_player),
        .x_enemy(x_enemy), .y_enemy(y_enemy), .enemy_en(enemy_en),
        .frozen(frz[1]), .grace(grc[1]), .hit_id(hid_o[1]), .ticks_left(tl[1]), .thaw(thw_o[1]));

    freeze_ctrl #(.TICK_DIV(D), .FREEZE_TICKS(F), .GRACE_TICKS(0), .RETRIGGER(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .x_player(x_player), .y_player(y_player),
        .x_enemy(x_enemy), .y_enemy(y_enemy), .enemy_en(enemy_en),
        .frozen(frz[2]), .grace(grc[2]), .hit_id(hid_o[2]), .ticks_left(tl[2]), .thaw(thw_o[2]));

    // Index of the lowest enabled enemy whose box the foot point touches, or -1.
    function automatic int winner();
        int fx, fy, xe, ye, d;
        fx = int'(x_player) + 24;
        fy = int'(y_player) + 41;
        for (int i = 0; i < 4; i++) begin
            xe = int'(x_enemy[10*i +: 10]);
            ye = int'(y_enemy[9*i +: 9]);
            d  = fy - ye;
            if (enemy_en[i] && fx > xe && fx < xe + 62 && d > -2 && d < 2)
                return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_ph[k] = 0; m_rem[k] = 0; m_hid[k] = 0; m_thw[k] = 0;
            end
        end else begin
            w = winner();
            for (int k = 0; k < 3; k++) begin
                m_thw[k] = 0;
                if (m_ph[k] == 0) begin
                    if (w >= 0) begin
                        m_ph[k] = 1; m_rem[k] = F * D; m_hid[k] = w;
                    end
                end else if (m_ph[k] == 1) begin
                    if (RT[k] != 0 && w >= 0) begin
                        m_rem[k] = F * D; m_hid[k] = w;
                    end else begin
                        m_rem[k]--;
                        if (m_rem[k] == 0) begin
                            m_thw[k] = 1;
                            m_ph[k]  = (GT[k] > 0) ? 2 : 0;
                            m_rem[k] = GT[k] * D;
                        end
                    end
                end else begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) m_ph[k] = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle, all three instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model%0d_frozen", k), int'(frz[k]), int'(m_ph[k] == 1));
                chk($sformatf("model%0d_grace", k), int'(grc[k]), int'(m_ph[k] == 2));
                chk($sformatf("model%0d_thaw", k), int'(thw_o[k]), m_thw[k]);
                chk($sformatf("model%0d_hit_id", k), int'(hid_o[k]), m_hid[k]);
                chk($sformatf("model%0d_ticks", k), int'(tl[k]),
                    (m_ph[k] == 0) ? 0 : (m_rem[k] + D - 1) / D);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_enemy(input int i, input int x, input int y);
        x_enemy[10*i +: 10] = 10'(x);
        y_enemy[9*i +: 9]   = 9'(y);
    endtask

    typedef struct { int x; int y; int hit; } bnd_t;
    bnd_t bnd[9] = '{'{62, 141, 0}, '{63, 141, 1}, '{124, 141, 0},
                     '{110, 139, 0}, '{110, 140, 1}, '{110, 142, 1},
                     '{110, 143, 0}, '{110, 138, 0}, '{110, 144, 0}};

    int fc[3], gc[3], tc[3];
    logic f0[22], g0[22], f2[22], t2[22];
    int r_all, r_th, g2_sum;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        chk_en = 1'b1;
        rst_n = 1'b1;
        cyc(1);
        chk("reset_frozen", int'(frz[0]), 0);
        chk("reset_ticks", int'(tl[0]), 0);
        chk("reset_hit_id", int'(hid_o[0]), 0);

        // single-channel hit on enemy 2
        set_enemy(2, 110, 141);
        enemy_en = 4'b0100;
        cyc(1);
        chk("single_frozen", int'(frz[0]), 1);
        chk("single_hit_id", int'(hid_o[0]), 2);
        chk("single_ticks", int'(tl[0]), 3);
        enemy_en = 4'b0000;
        fc = '{0, 0, 0}; gc = '{0, 0, 0}; tc = '{0, 0, 0};
        for (int s = 0; s < 30; s++) begin
            for (int k = 0; k < 3; k++) begin
                fc[k] += int'(frz[k]); gc[k] += int'(grc[k]); tc[k] += int'(thw_o[k]);
            end
            cyc(1);
        end
        chk("single_frozen_cycles", fc[0], 12);
        chk("single_thaw_pulses", tc[0], 1);
        chk("single_grace_cycles", gc[0], 8);
        chk("single_end_idle", int'(frz[0] | grc[0]), 0);
        chk("g0_frozen_cycles", fc[2], 12);
        chk("g0_thaw_pulses", tc[2], 1);
        chk("g0_grace_cycles", gc[2], 0);

        // boundary contacts, foot point (124,141)
        set_enemy(2, 0, 0);
        for (int b = 0; b < 9; b++) begin
            set_enemy(0, bnd[b].x, bnd[b].y);
            enemy_en = 4'b0001;
            cyc(1);
            chk($sformatf("boundary_%0d_%0d", bnd[b].x, bnd[b].y), int'(frz[0]), bnd[b].hit);
            enemy_en = 4'b0000;
            cyc(40);
        end

        // priority and enable
        set_enemy(0, 0, 0);
        set_enemy(1, 110, 141);
        set_enemy(3, 110, 141);
        enemy_en = 4'b1010;
        cyc(1);
        chk("prio_hit_id", int'(hid_o[0]), 1);
        enemy_en = 4'b0000;
        cyc(40);
        enemy_en = 4'b1000;
        cyc(1);
        chk("enable_hit_id", int'(hid_o[0]), 3);
        enemy_en = 4'b0000;
        cyc(40);
        cyc(3);
        chk("all_disabled_frozen", int'(frz[0]), 0);

        // held contact: retrigger behaviour
        set_enemy(1, 0, 0);
        set_enemy(3, 0, 0);
        set_enemy(0, 110, 141);
        enemy_en = 4'b0001;
        cyc(1);
        r_all = 1; r_th = 0; g2_sum = 0;
        for (int s = 0; s < 22; s++) begin
            f0[s] = frz[0]; g0[s] = grc[0]; f2[s] = frz[2]; t2[s] = thw_o[2];
            r_all &= int'(frz[1]); r_th += int'(thw_o[1]); g2_sum += int'(grc[2]);
            cyc(1);
        end
        chk("r0_frozen_last", int'(f0[11]), 1);
        chk("r0_frozen_end", int'(f0[12]), 0);
        chk("r0_grace_last", int'(g0[19]), 1);
        chk("r0_idle_gap", int'(f0[20] | g0[20]), 0);
        chk("r0_refreeze", int'(f0[21]), 1);
        chk("r1_never_drop", r_all, 1);
        chk("r1_no_thaw", r_th, 0);
        chk("g0_thaw_at_exit", int'(t2[12]), 1);
        chk("g0_no_grace", g2_sum, 0);
        chk("g0_refreeze", int'(f2[13]), 1);

        // reset mid-freeze
        enemy_en = 4'b0000;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        enemy_en = 4'b0001;
        cyc(1);
        enemy_en = 4'b0000;
        cyc(4);
        chk("midfreeze_frozen", int'(frz[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_frozen", int'(frz[0]), 0);
        chk("rst_grace", int'(grc[0]), 0);
        chk("rst_ticks", int'(tl[0]), 0);
        chk("rst_thaw", int'(thw_o[0]), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("post_rst_idle", int'(frz[0] | grc[0] | thw_o[0]), 0);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
